button_debounce_multi: RTL and testbench

//  Debounces NUM_BTN asynchronous push-buttons and drives one indicator output per

---
 rtl/button_pkg.sv | 15 +
 rtl/button_debounce_multi_if.sv | 22 ++
 rtl/button_debounce_ch.sv | 139 +++++++++++++
 rtl/button_debounce_multi.sv | 44 ++++
 tb/tb_button_debounce_multi.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the multi-channel button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic [1:0] MODE_PULSE  = 2'd0;
    localparam logic [1:0] MODE_LEVEL  = 2'd1;
    localparam logic [1:0] MODE_TOGGLE = 2'd2;

endpackage

// File: rtl/button_debounce_multi_if.sv
// Button pins, global LED mode and per-channel debounced status/event outputs.
interface button_debounce_multi_if #(
    parameter int NUM_BTN = 4
);
    logic [1:0]         mode;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_evt;
    logic [NUM_BTN-1:0] release_evt;
    logic [NUM_BTN-1:0] long_evt;
    logic [NUM_BTN-1:0] led;

    modport master (
        output mode, btn_in,
        input  btn_level, press_evt, release_evt, long_evt, led
    );

    modport slave (
        input  mode, btn_in,
        output btn_level, press_evt, release_evt, long_evt, led
    );
endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: synchroniser, debounce/hold FSM with saturating counters,
// one-cycle press/release/long events and the mode-selected LED output.
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 16777216,
    parameter int LONG_PRESS_CYC = 50331648,
    parameter int ACTIVE_LOW     = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_mode,
    input  logic       i_btn,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic       o_led
);
    localparam int CNT_W = $clog2(LONG_PRESS_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_AT  = CNT_W'(LONG_PRESS_CYC - DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_PRESS_CYC - DEBOUNCE_CYC);
    localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_act;
    btn_state_e             r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [CNT_W-1:0]       r_hold, w_hold_next, w_hold_inc;
    logic r_level, w_level_next, r_press, w_press_next, r_release, w_release_next;
    logic r_long, w_long_next, r_toggle, w_toggle_next, r_led, w_led_next;

    // Reset parks the synchroniser at the released level so no phantom press appears.
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= {SYNC_STAGES{INACTIVE}};
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end

    assign w_act      = r_sync[SYNC_STAGES-1] ^ INACTIVE;
    assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_toggle  <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hold    <= w_hold_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_long    <= w_long_next;
            r_toggle  <= w_toggle_next;
            r_led     <= w_led_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_hold_next    = r_hold;
        w_level_next   = r_level;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_long_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!w_act) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_hold_next  = '0;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                w_hold_next = w_hold_inc;
                w_long_next = (r_hold == LONG_AT);
                if (!w_act) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // Hold time survives a release bounce; the release event wins a tie with long.
                w_hold_next = w_hold_inc;
                if (w_act) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_long_next  = (r_hold == LONG_AT);
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next   = IDLE;
                    w_cnt_next     = '0;
                    w_level_next   = 1'b0;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next  = r_cnt + CNT_W'(1);
                    w_long_next = (r_hold == LONG_AT);
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_toggle_next = r_toggle ^ w_press_next;
        case (i_mode)
            MODE_PULSE:  w_led_next = w_press_next;
            MODE_TOGGLE: w_led_next = w_toggle_next;
            default:     w_led_next = w_level_next;
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_led     = r_led;

endmodule

// File: rtl/button_debounce_multi.sv
// NUM_BTN independent debounced button channels sharing one LED mode select.
module button_debounce_multi
    import button_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int DEBOUNCE_CYC   = 16777216,
    parameter int LONG_PRESS_CYC = 50331648,
    parameter int ACTIVE_LOW     = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debounce_multi_if.slave  bus
);
    logic [NUM_BTN-1:0] w_level, w_press, w_release, w_long, w_led;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            button_debounce_ch #(
                .DEBOUNCE_CYC   (DEBOUNCE_CYC),
                .LONG_PRESS_CYC (LONG_PRESS_CYC),
                .ACTIVE_LOW     (ACTIVE_LOW),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .i_mode    (bus.mode),
                .i_btn     (bus.btn_in[gi]),
                .o_level   (w_level[gi]),
                .o_press   (w_press[gi]),
                .o_release (w_release[gi]),
                .o_long    (w_long[gi]),
                .o_led     (w_led[gi])
            );
        end
    endgenerate

    assign bus.btn_level   = w_level;
    assign bus.press_evt   = w_press;
    assign bus.release_evt = w_release;
    assign bus.long_evt    = w_long;
    assign bus.led         = w_led;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed vector table plus hand-written glitch and mid-qualification reset sequences.
module tb_button_debounce_multi;
    localparam int NB   = 2;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int NV   = 37;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    button_debounce_multi_if #(.NUM_BTN(NB)) bus ();

    button_debounce_multi #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYC   (DEB),
        .LONG_PRESS_CYC (LONG),
        .ACTIVE_LOW     (1),
        .SYNC_STAGES    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       r;
        logic [1:0] m;
        logic [1:0] b;
        int         n;
        logic [1:0] lvl, prs, rel, lng, led;
    } vec_t;

    vec_t vecs [NV];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(input logic r, input logic [1:0] m, input logic [1:0] b,
                               input int n, input logic [1:0] lvl, input logic [1:0] prs,
                               input logic [1:0] rel, input logic [1:0] lng,
                               input logic [1:0] led);
        vec_t t;
        t.r = r; t.m = m; t.b = b; t.n = n;
        t.lvl = lvl; t.prs = prs; t.rel = rel; t.lng = lng; t.led = led;
        return t;
    endfunction

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] lvl, input logic [1:0] prs,
                       input logic [1:0] rel, input logic [1:0] lng, input logic [1:0] led);
        checks++;
        if ({bus.btn_level, bus.press_evt, bus.release_evt, bus.long_evt, bus.led}
            !== {lvl, prs, rel, lng, led}) begin
            errors++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b lng=%b led=%b, want lvl=%b prs=%b rel=%b lng=%b led=%b",
                     name, bus.btn_level, bus.press_evt, bus.release_evt, bus.long_evt, bus.led,
                     lvl, prs, rel, lng, led);
        end else begin
            $display("ok   %s: lvl=%b prs=%b rel=%b lng=%b led=%b",
                     name, bus.btn_level, bus.press_evt, bus.release_evt, bus.long_evt, bus.led);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    initial begin
        int seen;

        // rst, mode, btn, edges, level, press, release, long, led
        vecs[0]  = v(0, 0, 2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // in reset
        vecs[1]  = v(1, 0, 2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // released, idle
        vecs[2]  = v(1, 0, 2'b10,  9, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // ch0 not yet
        vecs[3]  = v(1, 0, 2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01); // ch0 press, edge k+10
        vecs[4]  = v(1, 0, 2'b10,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[5]  = v(1, 0, 2'b10,  9, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[6]  = v(1, 0, 2'b11,  9, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[7]  = v(1, 0, 2'b11,  1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00); // ch0 release
        vecs[8]  = v(1, 0, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[9]  = v(1, 0, 2'b10,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // short bounce
        vecs[10] = v(1, 0, 2'b11, 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // rejected
        vecs[11] = v(1, 0, 2'b01, 10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10); // ch1 press
        vecs[12] = v(1, 0, 2'b01, 23, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[13] = v(1, 0, 2'b01,  1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00); // long, edge k+34
        vecs[14] = v(1, 0, 2'b01,  1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[15] = v(1, 0, 2'b01,  5, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00); // held 40
        vecs[16] = v(1, 0, 2'b11,  9, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[17] = v(1, 0, 2'b11,  1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00); // ch1 release
        vecs[18] = v(1, 0, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[19] = v(0, 2, 2'b11,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // clear toggles
        vecs[20] = v(1, 2, 2'b11,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[21] = v(1, 2, 2'b10, 10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01); // toggle 0->1
        vecs[22] = v(1, 2, 2'b10,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        vecs[23] = v(1, 2, 2'b11, 10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        vecs[24] = v(1, 2, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        vecs[25] = v(1, 2, 2'b10, 10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00); // toggle 1->0
        vecs[26] = v(1, 1, 2'b10,  1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01); // LEVEL
        vecs[27] = v(1, 1, 2'b11, 10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        vecs[28] = v(1, 1, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[29] = v(1, 1, 2'b01, 10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
        vecs[30] = v(1, 1, 2'b11, 10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        vecs[31] = v(1, 2, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10); // toggle state shown
        vecs[32] = v(1, 3, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // mode 3 = LEVEL
        vecs[33] = v(1, 0, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11); // simultaneous
        vecs[34] = v(1, 0, 2'b00,  1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        vecs[35] = v(1, 0, 2'b11, 10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        vecs[36] = v(1, 0, 2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        rst        = 1'b0;
        bus.mode   = 2'd0;
        bus.btn_in = 2'b00;

        for (int i = 0; i < NV; i++) begin
            rst        = vecs[i].r;
            bus.mode   = vecs[i].m;
            bus.btn_in = vecs[i].b;
            step(vecs[i].n);
            chk($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel,
                vecs[i].lng, vecs[i].led);
        end

        // One-cycle release glitch on ch0 while pressed (LEVEL mode).
        bus.mode   = 2'd1;
        bus.btn_in = 2'b10;
        step(10);
        chk("glitch_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        step(3);
        chk("glitch_hold", 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        bus.btn_in = 2'b11;
        step(1);
        bus.btn_in = 2'b10;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (bus.btn_level !== 2'b01 || bus.release_evt !== 2'b00 || bus.long_evt !== 2'b00)
                seen++;
        end
        chk_int("glitch_no_release", seen, 0);
        bus.btn_in = 2'b11;
        step(10);
        chk("glitch_release", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        step(1);
        chk("glitch_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset in the middle of press qualification, buttons held throughout.
        bus.mode   = 2'd0;
        bus.btn_in = 2'b00;
        step(5);
        chk("pw_before_rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        step(1);
        chk("rst_mid_pw", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 9; c++) begin
            step(1);
            if ({bus.btn_level, bus.press_evt, bus.release_evt, bus.long_evt, bus.led} !== 10'd0)
                seen++;
        end
        chk_int("no_stale_event", seen, 0);
        step(1);
        chk("press_after_rst", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
